// File: rtl/spi_target_if.sv
// Bus bundle between an SPI target and its host-side logic/SPI master.
// slave modport is the target's view; master modport is the driving side.
interface spi_target_if;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       overrun_o;
    logic       underrun_o;
    logic       sck_i;
    logic       csn_i;
    logic       mosi_i;
    logic       miso_o;
    logic       miso_oe_o;

    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i, sck_i, csn_i, mosi_i,
        output tx_ready_o, rx_data_o, rx_valid_o, overrun_o, underrun_o, miso_o, miso_oe_o
    );

    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i, sck_i, csn_i, mosi_i,
        input  tx_ready_o, rx_data_o, rx_valid_o, overrun_o, underrun_o, miso_o, miso_oe_o
    );
endinterface

// File: rtl/spi_target.sv
// SPI target, mode 0, MSB first, oversampled on clk_i. Handshakes: a byte moves
// across tx or rx exactly in a cycle where valid and ready are both high.
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic clk_i,
    input  logic rst_i,
    spi_target_if.slave bus,
    output logic dbg_state
);
    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic       sck_q, csn_q;
    logic       sck_s, csn_s, mosi_s;
    logic       sck_rise, sck_fall, csn_rise, csn_fall;
    logic       load_evt, edges_en, byte_done;
    logic       load_next;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, hold_data;
    logic       hold_full;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, underrun;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign csn_rise = csn_s & ~csn_q;
    assign csn_fall = ~csn_s & csn_q;

    // csn chain resets low so a select held low across reset never looks like a fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            csn_sync  <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], bus.csn_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
            sck_q     <= sck_s;
            csn_q     <= csn_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_evt   = 1'b0;
        edges_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_next = ST_ACTIVE;
                    load_evt   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (csn_rise) begin
                    state_next = ST_IDLE;
                end else begin
                    edges_en = 1'b1;
                    load_evt = sck_fall & load_next;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign byte_done = edges_en & sck_rise & (bit_cnt == 3'd7);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_shift  <= IDLE_BYTE;
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            rx_shift  <= 8'h00;
            bit_cnt   <= 3'd0;
            load_next <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (load_evt) begin
                load_next <= 1'b0;
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else if (bus.tx_valid_i) begin
                    tx_shift <= bus.tx_data_i;
                end else begin
                    tx_shift <= IDLE_BYTE;
                    underrun <= 1'b1;
                end
            end else begin
                if (!hold_full && bus.tx_valid_i) begin
                    hold_data <= bus.tx_data_i;
                    hold_full <= 1'b1;
                end
                if (state == ST_ACTIVE && csn_rise) begin
                    tx_shift  <= IDLE_BYTE;
                    rx_shift  <= 8'h00;
                    bit_cnt   <= 3'd0;
                    load_next <= 1'b0;
                end else if (edges_en && sck_rise) begin
                    rx_shift <= {rx_shift[6:0], mosi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) load_next <= 1'b1;
                end else if (edges_en && sck_fall) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // A new byte landing on an unconsumed one overwrites it and flags overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_done) begin
                rx_data  <= {rx_shift[6:0], mosi_s};
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~bus.rx_ready_i;
            end else if (rx_valid && bus.rx_ready_i) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign bus.tx_ready_o = ~hold_full;
    assign bus.rx_data_o  = rx_data;
    assign bus.rx_valid_o = rx_valid;
    assign bus.overrun_o  = overrun;
    assign bus.underrun_o = underrun;
    assign bus.miso_o     = tx_shift[7];
    assign bus.miso_oe_o  = (state == ST_ACTIVE);
    assign dbg_state      = state;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bench plays the SPI master and the host side,
// checking received bytes through an expected queue and event counts per scenario.
module tb_spi_target;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;

    spi_target_if bus();

    spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int ovr_cnt = 0;
    int und_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted rx byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.overrun_o)  ovr_cnt++;
            if (bus.underrun_o) und_cnt++;
            if (bus.rx_valid_o && bus.rx_ready_i) begin
                acc_cnt++;
                if (exp_q.size() == 0) check("rx_unexpected", {24'h0, bus.rx_data_o}, 32'hFFFF_FFFF);
                else                   check("rx_data", {24'h0, bus.rx_data_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int waited = 0;
        while (!bus.tx_ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", {31'h0, bus.tx_ready_o}, 32'h1);
        bus.tx_data_i  = b;
        bus.tx_valid_i = 1'b1;
        @(negedge clk);
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] data, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.mosi_i = data[7-i];
            cycles(6);
            bus.sck_i = 1'b1;
            rx = {rx[6:0], bus.miso_o};
            cycles(6);
            bus.sck_i = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] data, output logic [7:0] rx);
        spi_bits(data, 8, rx);
    endtask

    task automatic csn_low();
        bus.csn_i = 1'b0;
        cycles(8);
    endtask

    task automatic csn_high();
        cycles(6);
        bus.csn_i = 1'b1;
        cycles(8);
    endtask

    initial begin
        logic [7:0] rx;
        int acc0, und0, ovr0;
        bus.tx_data_i  = 8'h00;
        bus.tx_valid_i = 1'b0;
        bus.rx_ready_i = 1'b1;
        bus.sck_i      = 1'b0;
        bus.csn_i      = 1'b1;
        bus.mosi_i     = 1'b0;
        cycles(4);
        rst = 1'b0;
        cycles(1);

        check("rst_tx_ready", {31'h0, bus.tx_ready_o}, 32'h1);
        check("rst_rx_valid", {31'h0, bus.rx_valid_o}, 32'h0);
        check("rst_rx_data",  {24'h0, bus.rx_data_o},  32'h0);
        check("rst_overrun",  {31'h0, bus.overrun_o},  32'h0);
        check("rst_underrun", {31'h0, bus.underrun_o}, 32'h0);
        check("rst_miso_oe",  {31'h0, bus.miso_oe_o},  32'h0);
        check("rst_miso",     {31'h0, bus.miso_o},     32'h1);
        check("rst_state",    {31'h0, dbg_state},      32'h0);
        cycles(8);

        // Single byte: A5 in, 3C out; 5A refills holding so the trailing load is not an underrun.
        acc0 = acc_cnt; und0 = und_cnt; ovr0 = ovr_cnt;
        push_tx(8'h3C);
        check("hold_full", {31'h0, bus.tx_ready_o}, 32'h0);
        csn_low();
        check("sel_oe",       {31'h0, bus.miso_oe_o}, 32'h1);
        check("sel_miso_msb", {31'h0, bus.miso_o},    32'h0);
        check("hold_emptied", {31'h0, bus.tx_ready_o}, 32'h1);
        push_tx(8'h5A);
        exp_q.push_back(8'hA5);
        spi_byte(8'hA5, rx);
        check("t1_miso_byte", {24'h0, rx}, 32'h3C);
        csn_high();
        check("t1_oe_off",   {31'h0, bus.miso_oe_o}, 32'h0);
        check("t1_accepts",  acc_cnt - acc0, 32'd1);
        check("t1_underrun", und_cnt - und0, 32'd0);
        check("t1_overrun",  ovr_cnt - ovr0, 32'd0);
        check("t1_last_rx",  {24'h0, bus.rx_data_o}, 32'hA5);

        // Burst of three with holding refilled each byte; 04 covers the trailing load.
        acc0 = acc_cnt; und0 = und_cnt;
        push_tx(8'h01);
        csn_low();
        push_tx(8'h02);
        exp_q.push_back(8'h10);
        spi_byte(8'h10, rx);
        check("t2_b0", {24'h0, rx}, 32'h01);
        push_tx(8'h03);
        exp_q.push_back(8'h20);
        spi_byte(8'h20, rx);
        check("t2_b1", {24'h0, rx}, 32'h02);
        push_tx(8'h04);
        exp_q.push_back(8'h30);
        spi_byte(8'h30, rx);
        check("t2_b2", {24'h0, rx}, 32'h03);
        csn_high();
        check("t2_accepts",  acc_cnt - acc0, 32'd3);
        check("t2_underrun", und_cnt - und0, 32'd0);

        // Nothing offered: every load (select plus after each byte) is IDLE_BYTE with a pulse.
        acc0 = acc_cnt; und0 = und_cnt;
        csn_low();
        check("t3_und_on_sel", und_cnt - und0, 32'd1);
        exp_q.push_back(8'h55);
        spi_byte(8'h55, rx);
        check("t3_b0", {24'h0, rx}, 32'hFF);
        exp_q.push_back(8'hAA);
        spi_byte(8'hAA, rx);
        check("t3_b1", {24'h0, rx}, 32'hFF);
        csn_high();
        check("t3_underrun", und_cnt - und0, 32'd3);
        check("t3_accepts",  acc_cnt - acc0, 32'd2);

        // Consumer stalled: 22 overwrites 11, one overrun pulse.
        acc0 = acc_cnt; ovr0 = ovr_cnt;
        bus.rx_ready_i = 1'b0;
        csn_low();
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        csn_high();
        check("t4_rx_valid", {31'h0, bus.rx_valid_o}, 32'h1);
        check("t4_rx_data",  {24'h0, bus.rx_data_o},  32'h22);
        check("t4_overrun",  ovr_cnt - ovr0, 32'd1);
        exp_q.push_back(8'h22);
        bus.rx_ready_i = 1'b1;
        cycles(2);
        check("t4_accepts",  acc_cnt - acc0, 32'd1);
        check("t4_drained",  {31'h0, bus.rx_valid_o}, 32'h0);

        // Deselect after four bits: partial byte dropped, next byte intact.
        acc0 = acc_cnt;
        csn_low();
        spi_bits(8'hF0, 4, rx);
        csn_high();
        check("t5_no_valid",   {31'h0, bus.rx_valid_o}, 32'h0);
        check("t5_no_accept",  acc_cnt - acc0, 32'd0);
        check("t5_oe_off",     {31'h0, bus.miso_oe_o}, 32'h0);
        exp_q.push_back(8'hC3);
        csn_low();
        spi_byte(8'hC3, rx);
        csn_high();
        check("t5_accepts",    acc_cnt - acc0, 32'd1);

        // Select held low across reset release must not start a transfer.
        bus.csn_i = 1'b0;
        cycles(4);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(8);
        acc0 = acc_cnt;
        check("t6_state_idle", {31'h0, dbg_state},      32'h0);
        check("t6_oe_off",     {31'h0, bus.miso_oe_o},  32'h0);
        spi_byte(8'h7E, rx);
        cycles(4);
        check("t6_ignored",    acc_cnt - acc0, 32'd0);
        check("t6_no_valid",   {31'h0, bus.rx_valid_o}, 32'h0);
        bus.csn_i = 1'b1;
        cycles(8);
        csn_low();
        check("t6_selected",   {31'h0, bus.miso_oe_o},  32'h1);
        exp_q.push_back(8'h96);
        spi_byte(8'h96, rx);
        csn_high();
        check("t6_accepts",    acc_cnt - acc0, 32'd1);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
